// File: rtl/key_event_ctrl_pkg.sv
// Shared types and constants for the key event controller.
//   intr_state_t  : interrupt sequencer states
//   KEY_PORT_DEF  : default IN port that returns and pops the head key code
//   STAT_PORT_DEF : default IN port that returns status and clears overflow
//   EMPTY_CODE    : read value of the key port when no key is queued
//   sat_count     : clamps a queue depth to the 3-bit status field
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT_RD,
    GAP
  } intr_state_t;

  localparam logic [7:0] KEY_PORT_DEF  = 8'h96;
  localparam logic [7:0] STAT_PORT_DEF = 8'h97;
  localparam logic [7:0] EMPTY_CODE    = 8'hFF;

  function automatic logic [2:0] sat_count(input int unsigned c);
    return 3'((c > 32'd7) ? 32'd7 : c);
  endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Scanner + MCU I/O bus bundle for key_event_ctrl.
//   press, data      : scanner key-valid level and 4-bit key code
//   port_id, io_strb : MCU port address and one-cycle IN strobe
//   in_data          : read data returned to the MCU
//   intr, ovf        : interrupt request and sticky overflow flag
// master = scanner/MCU side, slave = key_event_ctrl.
interface key_event_ctrl_if;

  logic       press;
  logic [3:0] data;
  logic [7:0] port_id;
  logic       io_strb;
  logic [7:0] in_data;
  logic       intr;
  logic       ovf;

  modport master (
    output press, data, port_id, io_strb,
    input  in_data, intr, ovf
  );

  modport slave (
    input  press, data, port_id, io_strb,
    output in_data, intr, ovf
  );

endinterface

// File: rtl/key_event_ctrl_fifo.sv
// Small key FIFO with synchronous active-low reset.
//   clk, rst_n  : clock and synchronous reset
//   push, wdata : write request and data
//   pop         : read request (ignored when empty)
//   full, empty : occupancy flags
//   count       : number of stored entries
//   head        : oldest entry, valid while not empty
// A push while full is accepted only when a pop happens in the same cycle.
module key_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count_q gates what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Keypad-to-MCU key event controller.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : scanner inputs (press, data), MCU IN decode (port_id,
//                io_strb, in_data), interrupt request (intr) and sticky
//                overflow flag (ovf)
// Each press rising edge queues one key. The interrupt sequencer emits one
// INTR_W-cycle pulse per pending key and waits for the MCU to read it.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned INTR_W    = 8,
  parameter logic [7:0]  KEY_PORT  = KEY_PORT_DEF,
  parameter logic [7:0]  STAT_PORT = STAT_PORT_DEF
) (
  input logic              clk,
  input logic              rst_n,
  key_event_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (INTR_W > 1) ? $clog2(INTR_W) : 1;

  logic          press_q;
  logic          push, pop, key_sel, stat_sel, ovf_set, stat_clr;
  logic          full, empty;
  logic [CW-1:0] count;
  logic [3:0]    head;
  logic          ovf_q;

  intr_state_t   state_q;
  logic [PW-1:0] pcnt_q;
  logic          popped_q;
  logic          intr_q;

  assign key_sel  = (bus.port_id == KEY_PORT);
  assign stat_sel = (bus.port_id == STAT_PORT);
  assign push     = bus.press & ~press_q;
  assign pop      = bus.io_strb & key_sel & ~empty;
  // A simultaneous pop frees the slot, so only an unpaired push overflows.
  assign ovf_set  = push & full & ~pop;
  assign stat_clr = bus.io_strb & stat_sel;

  key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.data),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      press_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      press_q <= bus.press;
      if (ovf_set)       ovf_q <= 1'b1;
      else if (stat_clr) ovf_q <= 1'b0;
    end
  end

  always_comb begin
    bus.in_data = 8'h00;
    if (key_sel) begin
      bus.in_data = empty ? EMPTY_CODE : {4'h0, head};
    end else if (stat_sel) begin
      bus.in_data = {ovf_q, 3'b000, 1'b0, sat_count(32'(count))};
    end
  end

  // popped_q remembers a read that arrived before the pulse finished, so the
  // sequencer skips WAIT_RD for a key that is already consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      popped_q <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q  <= PULSE;
            intr_q   <= 1'b1;
            pcnt_q   <= PW'(INTR_W - 1);
            popped_q <= pop;
          end
        end
        PULSE: begin
          if (pop) popped_q <= 1'b1;
          if (pcnt_q == '0) begin
            intr_q  <= 1'b0;
            state_q <= (popped_q | pop) ? GAP : WAIT_RD;
          end else begin
            pcnt_q <= pcnt_q - PW'(1);
          end
        end
        WAIT_RD: begin
          if (pop) state_q <= GAP;
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.intr = intr_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: a key scoreboard queue filled on
// press edges and drained on KEY_PORT reads, plus a port-decode vector table.
module tb_key_event_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  KEYP  = 8'h96;
  localparam logic [7:0]  STATP = 8'h97;

  logic clk;
  logic rst_n;

  key_event_ctrl_if bus ();

  key_event_ctrl #(
    .DEPTH     (DEPTH),
    .INTR_W    (8),
    .KEY_PORT  (KEYP),
    .STAT_PORT (STATP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [3:0] exp_q[$];
  int         mcount = 0;
  logic       movf   = 1'b0;

  // Interrupt monitor: rising-edge count and width of the last pulse.
  int   pulse_cnt  = 0;
  int   hi_run     = 0;
  int   last_width = 0;
  logic intr_prev  = 1'b0;

  always @(posedge clk) begin
    if (bus.intr) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0) last_width <= hi_run;
      hi_run <= 0;
    end
    if (bus.intr && !intr_prev) pulse_cnt <= pulse_cnt + 1;
    intr_prev <= bus.intr;
  end

  typedef struct {
    logic [7:0] port;
    logic       strb;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [3:0] code);
    if (mcount < int'(DEPTH)) begin
      exp_q.push_back(code);
      mcount++;
    end else begin
      movf = 1'b1;
    end
  endtask

  function automatic logic [7:0] stat_exp();
    logic [2:0] c3;
    c3 = (mcount > 7) ? 3'd7 : 3'(mcount);
    return {movf, 4'b0000, c3};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    mcount = 0;
    movf   = 1'b0;
  endtask

  task automatic press_key(input logic [3:0] code, input int hold);
    bus.press = 1'b1;
    bus.data  = code;
    tick();
    model_push(code);
    repeat (hold - 1) tick();
    bus.press = 1'b0;
    tick();
  endtask

  task automatic read_key(input string name);
    logic [7:0] e;
    bus.port_id = KEYP;
    bus.io_strb = 1'b1;
    #1;
    if (exp_q.size() > 0) begin
      e = {4'h0, exp_q.pop_front()};
      mcount--;
    end else begin
      e = 8'hFF;
    end
    check(name, bus.in_data, e);
    tick();
    bus.io_strb = 1'b0;
    bus.port_id = 8'h00;
  endtask

  task automatic read_stat(input string name);
    bus.port_id = STATP;
    bus.io_strb = 1'b1;
    #1;
    check(name, bus.in_data, stat_exp());
    tick();
    movf = 1'b0;
    bus.io_strb = 1'b0;
    bus.port_id = 8'h00;
  endtask

  task automatic wait_intr(input logic val, input string name);
    int k;
    k = 0;
    while (bus.intr !== val && k < 40) begin
      tick();
      k++;
    end
    check(name, bus.intr, val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] e;

    vecs[0] = '{port: 8'h20, strb: 1'b1, exp: 8'h00};
    vecs[1] = '{port: 8'h00, strb: 1'b1, exp: 8'h00};
    vecs[2] = '{port: 8'h95, strb: 1'b1, exp: 8'h00};
    vecs[3] = '{port: 8'h98, strb: 1'b0, exp: 8'h00};
    vecs[4] = '{port: 8'h97, strb: 1'b0, exp: 8'h02};
    vecs[5] = '{port: 8'h96, strb: 1'b0, exp: 8'h0C};
    vecs[6] = '{port: 8'hFF, strb: 1'b1, exp: 8'h00};

    rst_n       = 1'b0;
    bus.press   = 1'b0;
    bus.data    = 4'h0;
    bus.port_id = 8'h00;
    bus.io_strb = 1'b0;
    tick();
    do_reset();

    // Reset state.
    check("rst_intr", bus.intr, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    read_stat("rst_stat");
    read_key("rst_key");

    // Long press: one push, INTR rises two edges after PRESS, 8 cycles wide.
    do_reset();
    base = pulse_cnt;
    bus.press = 1'b1;
    bus.data  = 4'h5;
    tick();
    model_push(4'h5);
    check("lat_edge1", bus.intr, 1'b0);
    tick();
    check("lat_edge2", bus.intr, 1'b1);
    repeat (48) tick();
    bus.press = 1'b0;
    tick();
    check("long_pulses", pulse_cnt - base, 1);
    check("long_width", last_width, 8);
    read_stat("long_stat");
    read_key("long_key");
    check("long_gap", bus.intr, 1'b0);
    read_key("long_empty");

    // Three presses, then ordered reads with one pulse per key.
    do_reset();
    base = pulse_cnt;
    press_key(4'h3, 2);
    press_key(4'h7, 2);
    press_key(4'hA, 2);
    repeat (15) tick();
    check("three_pulse1", pulse_cnt - base, 1);
    read_stat("three_stat");
    for (int i = 0; i < 3; i++) begin
      read_key($sformatf("three_key%0d", i));
      check($sformatf("three_gap%0d", i), bus.intr, 1'b0);
      repeat (15) tick();
    end
    check("three_pulses", pulse_cnt - base, 3);
    check("three_width", last_width, 8);

    // Overflow: six presses into four entries.
    do_reset();
    for (int i = 1; i <= 6; i++) press_key(4'(i), 2);
    check("ovf_set", bus.ovf, 1'b1);
    read_stat("ovf_stat1");
    check("ovf_clr", bus.ovf, 1'b0);
    read_stat("ovf_stat2");
    for (int i = 0; i < 4; i++) read_key($sformatf("ovf_key%0d", i));
    read_key("ovf_empty");

    // Full FIFO with a push and pop in the same cycle.
    do_reset();
    for (int i = 8; i < 12; i++) press_key(4'(i), 2);
    bus.press   = 1'b1;
    bus.data    = 4'hC;
    bus.port_id = KEYP;
    bus.io_strb = 1'b1;
    #1;
    e = {4'h0, exp_q.pop_front()};
    mcount--;
    check("pp_head", bus.in_data, e);
    tick();
    model_push(4'hC);
    bus.press   = 1'b0;
    bus.io_strb = 1'b0;
    bus.port_id = 8'h00;
    tick();
    check("pp_ovf", bus.ovf, 1'b0);
    read_stat("pp_stat");
    // Overflow push and status read together: set wins.
    bus.press   = 1'b1;
    bus.data    = 4'hD;
    bus.port_id = STATP;
    bus.io_strb = 1'b1;
    #1;
    check("sw_stat", bus.in_data, stat_exp());
    tick();
    model_push(4'hD);
    bus.press   = 1'b0;
    bus.io_strb = 1'b0;
    bus.port_id = 8'h00;
    check("sw_ovf", bus.ovf, 1'b1);
    tick();
    read_stat("sw_stat2");
    for (int i = 0; i < 4; i++) read_key($sformatf("pp_key%0d", i));

    // Reset in the middle of a pulse with two keys queued.
    do_reset();
    press_key(4'h1, 1);
    press_key(4'h2, 1);
    wait_intr(1'b1, "mid_intr_hi");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    mcount = 0;
    movf   = 1'b0;
    check("mid_intr_lo", bus.intr, 1'b0);
    tick();
    check("mid_intr_idle", bus.intr, 1'b0);
    read_stat("mid_stat");
    read_key("mid_key");

    // Port decode table: no pop or clear outside the two ports.
    do_reset();
    press_key(4'hC, 2);
    press_key(4'hD, 2);
    for (int i = 0; i < 7; i++) begin
      bus.port_id = vecs[i].port;
      bus.io_strb = vecs[i].strb;
      #1;
      check($sformatf("vec%0d", i), bus.in_data, vecs[i].exp);
      tick();
      bus.io_strb = 1'b0;
    end
    bus.port_id = 8'h00;
    check("vec_ovf", bus.ovf, 1'b0);
    read_stat("vec_stat");
    read_key("vec_key0");
    read_key("vec_key1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
